// File: rtl/wb_mem_pkg.sv
// Shared definitions for the parameterised Wishbone slave memory:
// FSM state encodings and the byte-offset width helper.
package wb_mem_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Number of low address bits that select a byte within one DW-wide word.
  function automatic int off_bits(input int dw);
    return $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/wb_param_slave_mem_if.sv
// Wishbone classic bus bundle between one master and the slave memory.
interface wb_param_slave_mem_if #(
  parameter int DW = 32,
  parameter int AW = 32
);

  logic [DW-1:0]   data_i;
  logic [AW-1:0]   adr_i;
  logic            we_i;
  logic [DW/8-1:0] sel_i;
  logic            stb_i;
  logic            cyc_i;
  logic [DW-1:0]   data_o;
  logic            ack_o;
  logic            err_o;

  modport master (
    output data_i, adr_i, we_i, sel_i, stb_i, cyc_i,
    input  data_o, ack_o, err_o
  );

  modport slave (
    input  data_i, adr_i, we_i, sel_i, stb_i, cyc_i,
    output data_o, ack_o, err_o
  );

endinterface

// File: rtl/wb_mem_array.sv
// DEPTH x DW register array: per-byte write enables, synchronous clear,
// asynchronous read port.
module wb_mem_array #(
  parameter int DW    = 32,
  parameter int DEPTH = 16,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            we_i,
  input  logic [DW/8-1:0] be_i,
  input  logic [IW-1:0]   addr_i,
  input  logic [DW-1:0]   wdata_i,
  output logic [DW-1:0]   rdata_o
);

  logic [DEPTH-1:0][DW-1:0] mem_q, mem_d;

  // NOTE: combinational blocks use blocking '=' and start from a full default
  // so no path leaves mem_d unassigned and no latch is inferred.
  always_comb begin
    mem_d = mem_q;
    if (we_i) begin
      for (int k = 0; k < DW / 8; k++) begin
        if (be_i[k]) mem_d[addr_i][8*k +: 8] = wdata_i[8*k +: 8];
      end
    end
  end

  // NOTE: the array lives in flops rather than a RAM macro, so it can and must
  // be cleared by reset; sequential state is only ever updated with '<='.
  always_ff @(posedge clk_i) begin
    if (rst_i) mem_q <= '0;
    else       mem_q <= mem_d;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/wb_param_slave_mem.sv
// Wishbone slave memory with configurable wait states: FSM, wait counter,
// address decode and registered ack/err/data outputs around wb_mem_array.
module wb_param_slave_mem
  import wb_mem_pkg::*;
#(
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  wb_param_slave_mem_if.slave  bus
);

  localparam int OB = off_bits(DW);
  localparam int IW = $clog2(DEPTH);

  logic          req;
  logic [AW-1:0] word_idx;
  logic          in_range;
  logic [IW-1:0] mem_addr;
  logic [DW-1:0] rd_data;
  logic          wr_en;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic [DW-1:0] data_q, data_d;

  assign req      = bus.cyc_i & bus.stb_i;
  assign word_idx = bus.adr_i >> OB;
  assign in_range = word_idx < AW'(DEPTH);
  assign mem_addr = word_idx[IW-1:0];

  // Terminations are registered at the edge that ends DONE, which is also the
  // write-commit edge; dropping the request at that edge aborts cleanly.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    data_d  = '0;
    wr_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      ST_WAIT: begin
        if (!req) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (req) begin
          if (in_range) begin
            ack_d = 1'b1;
            wr_en = bus.we_i;
            if (!bus.we_i) data_d = rd_data;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  wb_mem_array #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_mem (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (wr_en),
    .be_i    (bus.sel_i),
    .addr_i  (mem_addr),
    .wdata_i (bus.data_i),
    .rdata_o (rd_data)
  );

  assign bus.ack_o  = ack_q;
  assign bus.err_o  = err_q;
  assign bus.data_o = data_q;

endmodule

// File: tb/tb_wb_param_slave_mem.sv
// Directed bench for wb_param_slave_mem: one instance with two wait states,
// one with none for the back-to-back sequence.
module tb_wb_param_slave_mem;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  wb_param_slave_mem_if #(.DW(DW), .AW(AW)) bus2 ();
  wb_param_slave_mem_if #(.DW(DW), .AW(AW)) bus0 ();

  wb_param_slave_mem #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .WAIT_CYCLES(2)) u_dut2 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus2.slave)
  );

  wb_param_slave_mem #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus0.slave)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] data;
    logic [3:0]  sel;
    logic        exp_ack;
    logic        exp_err;
    logic [31:0] exp_data;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input bit w0, input logic cyc, input logic stb, input logic we,
                       input logic [31:0] adr, input logic [31:0] data, input logic [3:0] sel);
    if (w0) begin
      bus0.cyc_i = cyc; bus0.stb_i = stb; bus0.we_i = we;
      bus0.adr_i = adr; bus0.data_i = data; bus0.sel_i = sel;
    end else begin
      bus2.cyc_i = cyc; bus2.stb_i = stb; bus2.we_i = we;
      bus2.adr_i = adr; bus2.data_i = data; bus2.sel_i = sel;
    end
  endtask

  task automatic sample(input bit w0, output logic ack, output logic err, output logic [31:0] dat);
    if (w0) begin
      ack = bus0.ack_o; err = bus0.err_o; dat = bus0.data_o;
    end else begin
      ack = bus2.ack_o; err = bus2.err_o; dat = bus2.data_o;
    end
  endtask

  task automatic idle(input bit w0);
    drive(w0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  // Called at a falling edge; lat counts rising edges after the sampling edge.
  task automatic access(input bit w0, input logic we, input logic [31:0] adr,
                        input logic [31:0] data, input logic [3:0] sel,
                        output logic ack, output logic err, output logic [31:0] dat,
                        output int lat);
    logic a, e;
    logic [31:0] d;
    drive(w0, 1'b1, 1'b1, we, adr, data, sel);
    ack = 1'b0; err = 1'b0; dat = '0; lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); @(negedge clk);
      sample(w0, a, e, d);
      if (a || e) begin
        ack = a; err = e; dat = d; lat = i;
        break;
      end
    end
    idle(w0);
    @(negedge clk);
  endtask

  task automatic no_term(input bit w0, input string name, input int cycles);
    logic a, e;
    logic [31:0] d;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); @(negedge clk);
      sample(w0, a, e, d);
      check($sformatf("%s c%0d ack/err", name, i), {a, e}, 2'b00);
    end
  endtask

  task automatic read_check(input bit w0, input string name, input logic [31:0] adr,
                            input logic [31:0] exp, input int exp_lat);
    logic a, e;
    logic [31:0] d;
    int lat;
    access(w0, 1'b0, adr, 32'h0, 4'hF, a, e, d, lat);
    check({name, " ack"}, a, 1'b1);
    check({name, " data"}, d, exp);
    check({name, " latency"}, lat, exp_lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  initial begin
    vec_t vecs[14];
    logic a, e;
    logic [31:0] d;
    int lat;

    vecs[0]  = '{1'b1, 32'h28, 32'hDEADBEEF, 4'hF,    1'b1, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h28, 32'h0,        4'hF,    1'b1, 1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 32'h28, 32'h0000AA00, 4'b0010, 1'b1, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 32'h28, 32'h0,        4'hF,    1'b1, 1'b0, 32'hDEADAAEF};
    vecs[4]  = '{1'b1, 32'h40, 32'h11111111, 4'hF,    1'b0, 1'b1, 32'h0};
    vecs[5]  = '{1'b0, 32'h00, 32'h0,        4'hF,    1'b1, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, 32'h0C, 32'hCAFEF00D, 4'hF,    1'b1, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 32'h0F, 32'h0,        4'hF,    1'b1, 1'b0, 32'hCAFEF00D};
    vecs[8]  = '{1'b1, 32'h0C, 32'h12345678, 4'h0,    1'b1, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 32'h0C, 32'h0,        4'hF,    1'b1, 1'b0, 32'hCAFEF00D};
    vecs[10] = '{1'b0, 32'h3C, 32'h0,        4'hF,    1'b1, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 32'h44, 32'h0,        4'hF,    1'b0, 1'b1, 32'h0};
    vecs[12] = '{1'b1, 32'h3C, 32'hA1B2C3D4, 4'b1001, 1'b1, 1'b0, 32'h0};
    vecs[13] = '{1'b0, 32'h3C, 32'h0,        4'hF,    1'b1, 1'b0, 32'hA10000D4};

    rst = 1'b1;
    idle(1'b0);
    idle(1'b1);
    repeat (3) @(negedge clk);
    sample(1'b0, a, e, d);
    check("reset dut2 ack/err", {a, e}, 2'b00);
    check("reset dut2 data", d, 32'h0);
    sample(1'b1, a, e, d);
    check("reset dut0 ack/err", {a, e}, 2'b00);
    check("reset dut0 data", d, 32'h0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      access(1'b0, vecs[i].we, vecs[i].adr, vecs[i].data, vecs[i].sel, a, e, d, lat);
      check($sformatf("v%0d ack", i), a, vecs[i].exp_ack);
      check($sformatf("v%0d err", i), e, vecs[i].exp_err);
      check($sformatf("v%0d data", i), d, vecs[i].exp_data);
      check($sformatf("v%0d latency", i), lat, 3);
    end

    // Strobe dropped one cycle into WAIT.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h0C, 32'h12345678, 4'hF);
    @(posedge clk); @(negedge clk);
    idle(1'b0);
    no_term(1'b0, "abort_wait", 5);
    read_check(1'b0, "abort_wait readback", 32'h0C, 32'hCAFEF00D, 3);

    // Strobe dropped in the DONE cycle, before the terminating edge.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h0C, 32'h87654321, 4'hF);
    repeat (3) begin @(posedge clk); @(negedge clk); end
    idle(1'b0);
    no_term(1'b0, "abort_done", 3);
    read_check(1'b0, "abort_done readback", 32'h0C, 32'hCAFEF00D, 3);

    // Reset during WAIT with the request held across the would-be ack edge.
    access(1'b0, 1'b1, 32'h28, 32'hDEADBEEF, 4'hF, a, e, d, lat);
    check("pre-reset write ack", a, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h28, 32'h55555555, 4'hF);
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    no_term(1'b0, "reset_wait", 3);
    rst = 1'b0;
    idle(1'b0);
    read_check(1'b0, "post-reset 0x28", 32'h28, 32'h0, 3);
    read_check(1'b0, "post-reset 0x0C", 32'h0C, 32'h0, 3);

    // Zero wait states, strobe held high across two writes.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h28, 32'h11111111, 4'hF);
    @(posedge clk); @(negedge clk);
    sample(1'b1, a, e, d);
    check("b2b c0 ack", a, 1'b0);
    @(posedge clk); @(negedge clk);
    sample(1'b1, a, e, d);
    check("b2b c1 ack", a, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h30, 32'h22222222, 4'hF);
    @(posedge clk); @(negedge clk);
    sample(1'b1, a, e, d);
    check("b2b c2 ack", a, 1'b0);
    @(posedge clk); @(negedge clk);
    sample(1'b1, a, e, d);
    check("b2b c3 ack", a, 1'b1);
    check("b2b c3 err", e, 1'b0);
    idle(1'b1);
    @(posedge clk); @(negedge clk);
    sample(1'b1, a, e, d);
    check("b2b c4 ack", a, 1'b0);
    read_check(1'b1, "b2b readback 0x28", 32'h28, 32'h11111111, 1);
    read_check(1'b1, "b2b readback 0x30", 32'h30, 32'h22222222, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_param_slave_mem.md
WB_PARAM_SLAVE_MEM -- requirements
Module: wb_param_slave_mem

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk_i and rst_i, with rst_i sampled only on the rising edge of clk_i.
REQ-002 Parameter DW, default 32, SHALL set the data width; legal values are 8, 16, 32 or 64.
REQ-003 Parameter AW, default 32, SHALL set the byte-address width.
REQ-004 Parameter DEPTH, default 16, SHALL set the number of DW-wide words; legal range is 2..1024.
REQ-005 Parameter WAIT_CYCLES, default 0, SHALL set the wait states inserted before each ack/err; legal range is 0..15.
REQ-006 Port clk_i, input, 1 bit: rising-edge clock.
REQ-007 Port rst_i, input, 1 bit: synchronous active-high reset.
REQ-008 Port data_i, input, DW bits: write data.
REQ-009 Port adr_i, input, AW bits: byte address.
REQ-010 Port we_i, input, 1 bit: 1 = write, 0 = read.
REQ-011 Port sel_i, input, DW/8 bits: byte-lane enables; bit k covers data bits [8k+7:8k].
REQ-012 Port stb_i, input, 1 bit: strobe.
REQ-013 Port cyc_i, input, 1 bit: bus cycle valid.
REQ-014 Port data_o, output, DW bits: read data.
REQ-015 Port ack_o, output, 1 bit: normal termination.
REQ-016 Port err_o, output, 1 bit: error termination for an out-of-range address.

Function
REQ-017 Word index SHALL be adr_i >> log2(DW/8); the low log2(DW/8) address bits SHALL be ignored.
REQ-018 An access is in range when word index < DEPTH; otherwise it is out of range.
REQ-019 The FSM SHALL have three states: IDLE, WAIT, DONE.
REQ-020 IDLE SHALL move to WAIT when cyc_i & stb_i and WAIT_CYCLES > 0 (wait counter loaded with WAIT_CYCLES-1), and directly to DONE when cyc_i & stb_i and WAIT_CYCLES = 0.
REQ-021 In WAIT the counter SHALL decrement each cycle; the FSM SHALL enter DONE when the counter is 0.
REQ-022 Latency: ack_o or err_o SHALL assert exactly WAIT_CYCLES+1 cycles after the edge at which cyc_i & stb_i was first sampled in IDLE.
REQ-023 In DONE, ack_o (in range) or err_o (out of range) SHALL be high for exactly one cycle, never both, and the FSM SHALL then return to IDLE.
REQ-024 Back-to-back accesses: with cyc_i & stb_i still high in the IDLE cycle after DONE, a new access SHALL start, giving at least one idle cycle between terminations.
REQ-025 Abort: if cyc_i or stb_i is low in any WAIT cycle, or at the DONE edge, the FSM SHALL return to IDLE with no ack_o, no err_o and no write.
REQ-026 The in-range write SHALL commit at the rising edge ending the DONE cycle, updating only the lanes whose sel_i bit is 1; sel_i = 0 SHALL still produce ack_o with memory unchanged.
REQ-027 adr_i, we_i, data_i and sel_i SHALL be sampled in the DONE cycle; the master holds them stable during the access.
REQ-028 data_o SHALL carry mem[word index] while ack_o is high on a read, and SHALL be 0 at all other times, including writes and err_o cycles.
REQ-029 An out-of-range write SHALL NOT modify any memory word.

Reset
REQ-030 While rst_i is high at a clock edge: state = IDLE, wait counter = 0, ack_o = 0, err_o = 0, data_o = 0, and every memory word = 0.
REQ-031 Reset asserted during WAIT or DONE SHALL cancel the access; no write SHALL commit and no ack_o or err_o SHALL assert.
REQ-032 In the first cycle after rst_i deasserts, the FSM SHALL be in IDLE and able to accept an access.

Structure
REQ-033 Package wb_mem_pkg SHALL hold the FSM state enum (IDLE/WAIT/DONE) and the helper function that computes the byte-offset bit count from DW.
REQ-034 Sub-module wb_mem_array SHALL implement the DEPTH x DW register array with per-byte write enables, synchronous clear and an asynchronous read port.
REQ-035 The top level SHALL contain the FSM, wait counter, address decode and output registers.

Verification (DW=32, DEPTH=16, WAIT_CYCLES=2 unless noted)
REQ-036 Write 0xDEADBEEF to adr 0x28, sel 4'hF, then read adr 0x28 -> ack_o 3 cycles after stb_i each time; read data_o = 0xDEADBEEF.
REQ-037 Write 0x0000AA00 to adr 0x28 with sel 4'b0010, then read -> data_o = 0xDEADAAEF.
REQ-038 Write to adr 0x40 (word 16) -> err_o one-cycle pulse, ack_o stays 0; a read of word 0 is unchanged.
REQ-039 Drop stb_i one cycle into WAIT on a write of 0x12345678 to adr 0x0C -> no ack_o/err_o; a later read of 0x0C returns its prior value.
REQ-040 Assert rst_i during WAIT after a prior write of 0xDEADBEEF to 0x28 -> no termination; a subsequent read of 0x28 returns 0.
REQ-041 With WAIT_CYCLES=0, back-to-back writes to 0x28 and 0x30 with stb_i held high -> ack_o at cycles 1 and 3 with one idle cycle between.
